// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RISC-V core: sequences the shared ALU, unified memory and extender.
// Define MEM_WAIT_EN to add mem_ready, which stalls FETCH, MEMREAD and MEMWRITE until memory is ready.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_op
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpBeq  = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10
  } state_e;

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   ir_we, pc_we, reg_we, mem_we, illegal;
  logic [2:0] alu_funct;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_e'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    unique case (op)
      OpSw:    ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Only R-type can subtract; an I-type with bit 30 set is still an add.
  always_comb begin
    unique case (funct3)
      3'b000:  alu_funct = (funct7b5 && op[5]) ? 3'b001 : 3'b000;
      3'b010:  alu_funct = 3'b101;
      3'b110:  alu_funct = 3'b011;
      3'b111:  alu_funct = 3'b010;
      default: alu_funct = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    AdrSrc     = 1'b0;
    ALUControl = 3'b000;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
        if (mem_rdy) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecR;
          OpI:        state_d = StExecI;
          OpBeq:      state_d = StBeq;
          OpJal:      state_d = StJal;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_rdy) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc = 1'b1;
        mem_we = mem_rdy;
        if (mem_rdy) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
        state_d    = StAluWb;
      end
      StAluWb: begin
        reg_we  = 1'b1;
        state_d = StFetch;
      end
      StBeq: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_we      = Zero;
        state_d    = StFetch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Enables are forced low while reset is held, whatever state we are in.
  assign IRWrite    = ir_we & ~reset;
  assign PCWrite    = pc_we & ~reset;
  assign RegWrite   = reg_we & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign illegal_op = illegal & ~reset;

endmodule
